// File: rtl/cl_cntr_pkg.sv
// Shared types and constants for the cache-line counter sequencer.
package cl_cntr_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LINE_W  = 4;
  localparam int unsigned CNTR_AW = 21;
  localparam int unsigned CNTR_DW = 16;
  localparam int unsigned WDOG_W  = 4;
  localparam int unsigned DONE_TO = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_CAP,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_TMO,
    ST_OUT
  } state_t;

  // Payload handed to the pad engine.
  typedef struct packed {
    logic [CNTR_AW-1:0] tag;
    logic [CNTR_DW-1:0] cntr;
    logic               wr;
    logic               err;
  } nonce_t;

  // Counter-buffer tag of a physical line address.
  function automatic logic [CNTR_AW-1:0] tag_of(input logic [ADDR_W-1:0] addr);
    return addr[CNTR_AW+LINE_W-1:LINE_W];
  endfunction

endpackage

// File: rtl/cl_cntr_ctrl_wdog.sv
// Loadable down-counter; flags expiry while enabled and at zero.
module cl_cntr_wdog
  import cl_cntr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [WDOG_W-1:0] i_load_val,
  input  logic              i_en,
  output logic              o_expire_c
);

  logic [WDOG_W-1:0] r_cnt;

  // Reload on every buffer strobe, count down while waiting, hold at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WDOG_W'(1);
    end
  end

  assign o_expire_c = i_en && (r_cnt == '0);

endmodule

// File: rtl/cl_cntr_ctrl.sv
// Sequencer in front of the cache-line encryption counter buffer: runs the
// eval/store/done handshake and emits a {tag, counter} nonce to the pad engine.
// Optional feature macro: CL_CNTR_CTRL_LASTHIT_EN (reuse the last refill read).
module cl_cntr_ctrl
  import cl_cntr_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_wr,
  input  logic [ADDR_W-1:0]  i_req_addr,
  output logic               o_cntr_eval,
  output logic               o_cntr_store,
  output logic               o_cntr_invalid,
  output logic [CNTR_AW-1:0] o_tag_addr,
  input  logic               i_cntr_done,
  input  logic [CNTR_DW-1:0] i_cntr,
  output logic               o_nonce_valid,
  input  logic               i_nonce_ready,
  output logic [CNTR_AW-1:0] o_nonce_tag,
  output logic [CNTR_DW-1:0] o_nonce_cntr,
  output logic               o_nonce_wr,
  output logic               o_nonce_err,
  output logic               o_ovf_err
);

  state_t             r_state;
  state_t             w_nxt_state;
  logic               r_req_ready;
  logic               r_cntr_eval;
  logic               r_cntr_store;
  logic               r_cntr_invalid;
  logic               r_nonce_valid;
  logic               r_ovf_err;
  logic               r_wr;
  logic [CNTR_AW-1:0] r_tag_addr;
  logic [CNTR_DW-1:0] r_cap;
  nonce_t             r_nonce;
  nonce_t             w_nonce;
  logic               w_accept;
  logic               w_load_out;
  logic               w_wrap;
  logic               w_wd_load;
  logic               w_wd_en;
  logic               w_wd_expire;
  logic               w_hit;
  logic [CNTR_DW-1:0] w_last_cntr;
  logic [CNTR_AW-1:0] w_req_tag;
  logic               w_unused_addr;

  assign w_req_tag     = tag_of(i_req_addr);
  assign w_unused_addr = ^{i_req_addr[ADDR_W-1:CNTR_AW+LINE_W], i_req_addr[LINE_W-1:0]};

`ifdef CL_CNTR_CTRL_LASTHIT_EN
  logic [CNTR_AW-1:0] r_last_tag;
  logic [CNTR_DW-1:0] r_last_cntr;
  logic               r_last_vld;

  assign w_hit       = !i_req_wr && r_last_vld && (r_last_tag == w_req_tag);
  assign w_last_cntr = r_last_cntr;

  // Remember the most recent successful refill read; writebacks and timeouts invalidate it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_tag  <= '0;
      r_last_cntr <= '0;
      r_last_vld  <= 1'b0;
    end else if ((r_state == ST_RD_CAP) && !r_wr) begin
      r_last_tag  <= r_tag_addr;
      r_last_cntr <= i_cntr;
      r_last_vld  <= 1'b1;
    end else if ((w_accept && i_req_wr) || (r_state == ST_TMO)) begin
      r_last_vld  <= 1'b0;
    end
  end
`else
  assign w_hit       = 1'b0;
  assign w_last_cntr = '0;
`endif

  assign w_accept  = i_req_valid && r_req_ready && (r_state == ST_IDLE);
  assign w_wd_load = (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ);
  assign w_wd_en   = (r_state == ST_RD_WAIT) || (r_state == ST_WR_WAIT);
  assign w_wrap    = &r_cap;

  cl_cntr_wdog u_wdog (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_wd_load),
    .i_load_val (WDOG_W'(DONE_TO - 1)),
    .i_en       (w_wd_en),
    .o_expire_c (w_wd_expire)
  );

  // Next state and the nonce payload loaded on entry to OUT.
  always_comb begin
    w_nxt_state  = r_state;
    w_load_out   = 1'b0;
    w_nonce.tag  = r_tag_addr;
    w_nonce.cntr = '0;
    w_nonce.wr   = r_wr;
    w_nonce.err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_hit) begin
            w_nxt_state  = ST_OUT;
            w_load_out   = 1'b1;
            w_nonce.tag  = w_req_tag;
            w_nonce.cntr = w_last_cntr;
            w_nonce.wr   = 1'b0;
          end else begin
            w_nxt_state  = ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ:  w_nxt_state = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (i_cntr_done) begin
          w_nxt_state = ST_RD_CAP;
        end else if (w_wd_expire) begin
          w_nxt_state = ST_TMO;
        end
      end
      ST_RD_CAP: begin
        if (r_wr) begin
          w_nxt_state  = ST_WR_REQ;
        end else begin
          w_nxt_state  = ST_OUT;
          w_load_out   = 1'b1;
          w_nonce.cntr = i_cntr;
        end
      end
      ST_WR_REQ:  w_nxt_state = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (i_cntr_done) begin
          w_nxt_state  = ST_OUT;
          w_load_out   = 1'b1;
          w_nonce.cntr = r_cap + CNTR_DW'(1);
        end else if (w_wd_expire) begin
          w_nxt_state  = ST_TMO;
        end
      end
      ST_TMO: begin
        w_nxt_state = ST_OUT;
        w_load_out  = 1'b1;
        w_nonce.err = 1'b1;
      end
      ST_OUT: begin
        if (i_nonce_ready) begin
          w_nxt_state = ST_IDLE;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Registered strobes, request capture, nonce payload and sticky wrap flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_ready    <= 1'b0;
      r_cntr_eval    <= 1'b0;
      r_cntr_store   <= 1'b0;
      r_cntr_invalid <= 1'b0;
      r_nonce_valid  <= 1'b0;
      r_ovf_err      <= 1'b0;
      r_wr           <= 1'b0;
      r_tag_addr     <= '0;
      r_cap          <= '0;
      r_nonce        <= '0;
    end else begin
      r_req_ready    <= (w_nxt_state == ST_IDLE);
      r_cntr_eval    <= (w_nxt_state == ST_RD_REQ);
      r_cntr_store   <= (w_nxt_state == ST_WR_REQ);
      r_cntr_invalid <= (w_nxt_state == ST_TMO);
      r_nonce_valid  <= (w_nxt_state == ST_OUT);
      if (w_accept) begin
        r_tag_addr <= w_req_tag;
        r_wr       <= i_req_wr;
      end
      if (r_state == ST_RD_CAP) begin
        r_cap <= i_cntr;
      end
      if (w_load_out) begin
        r_nonce <= w_nonce;
      end
      if (w_load_out && (r_state == ST_WR_WAIT) && w_wrap) begin
        r_ovf_err <= 1'b1;
      end
    end
  end

  assign o_req_ready    = r_req_ready;
  assign o_cntr_eval    = r_cntr_eval;
  assign o_cntr_store   = r_cntr_store;
  assign o_cntr_invalid = r_cntr_invalid;
  assign o_tag_addr     = r_tag_addr;
  assign o_nonce_valid  = r_nonce_valid;
  assign o_nonce_tag    = r_nonce.tag;
  assign o_nonce_cntr   = r_nonce.cntr;
  assign o_nonce_wr     = r_nonce.wr;
  assign o_nonce_err    = r_nonce.err;
  assign o_ovf_err      = r_ovf_err;

endmodule
